md_sched: RTL and testbench

MD_SCHED -- requirements
Module: md_sched

---
 rtl/md_pkg.sv | 26 ++
 rtl/md_sched_if.sv | 23 ++
 rtl/md_arith.sv | 49 ++++
 rtl/md_sched.sv | 113 +++++++++++
 tb/tb_md_sched.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/md_pkg.sv
// Shared definitions for the HI/LO multiply/divide scheduler: op codes,
// FSM states and default latencies.
package md_pkg;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MFHI  = 4'd5,
    OP_MFLO  = 4'd6,
    OP_MTHI  = 4'd7,
    OP_MTLO  = 4'd8
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MUL_RUN = 2'd1,
    ST_DIV_RUN = 2'd2
  } md_state_e;

  localparam int MULT_LAT_DEF = 5;
  localparam int DIV_LAT_DEF  = 10;

endpackage

// File: rtl/md_sched_if.sv
// EX-stage request / result bundle between the pipeline and the HI/LO scheduler.
interface md_sched_if;
  logic        op_valid;
  logic [3:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        clear;
  logic        id_md;
  logic        start;
  logic        busy;
  logic        stall;
  logic [31:0] md_out;

  modport master (
    output op_valid, op, src_a, src_b, clear, id_md,
    input  start, busy, stall, md_out
  );

  modport slave (
    input  op_valid, op, src_a, src_b, clear, id_md,
    output start, busy, stall, md_out
  );
endinterface

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath producing the 64-bit {hi, lo} result
// and a divide-by-zero flag.
module md_arith
  import md_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [3:0]  i_op,
  output logic [63:0] o_res,
  output logic        o_div_by_zero
);

  logic [31:0]        w_b_safe;
  logic signed [31:0] w_sa;
  logic signed [31:0] w_sb;
  logic signed [31:0] w_q;
  logic signed [31:0] w_r;

  always_comb begin
    o_res         = '0;
    o_div_by_zero = 1'b0;
    w_b_safe      = (i_b == 32'd0) ? 32'd1 : i_b;
    w_sa          = $signed(i_a);
    w_sb          = $signed(w_b_safe);
    w_q           = '0;
    w_r           = '0;
    case (i_op)
      OP_MULT:  o_res = {{32{i_a[31]}}, i_a} * {{32{i_b[31]}}, i_b};
      OP_MULTU: o_res = {32'd0, i_a} * {32'd0, i_b};
      OP_DIV: begin
        o_div_by_zero = (i_b == 32'd0);
        // The only quotient that overflows 32 bits; handled explicitly.
        if (i_a == 32'h8000_0000 && i_b == 32'hFFFF_FFFF) begin
          o_res = {32'd0, 32'h8000_0000};
        end else begin
          w_q   = w_sa / w_sb;
          w_r   = w_sa % w_sb;
          o_res = {w_r, w_q};
        end
      end
      OP_DIVU: begin
        o_div_by_zero = (i_b == 32'd0);
        o_res         = {i_a % w_b_safe, i_a / w_b_safe};
      end
      default: o_res = '0;
    endcase
  end

endmodule

// File: rtl/md_sched.sv
// HI/LO scheduler: accepts multi-cycle MULT/DIV ops, holds busy for the
// configured latency, then commits the latched result into HI/LO.
//
//   state      | meaning
//   IDLE       | ready; MULT/DIV may start, MTHI/MTLO write immediately
//   MUL_RUN    | multiply in flight, counting down MULT_LAT cycles
//   DIV_RUN    | divide in flight, counting down DIV_LAT cycles
module md_sched
  import md_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF
) (
  input  logic       clk,
  input  logic       reset,
  md_sched_if.slave  md_if
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  md_state_e        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [63:0]      r_res;
  logic             r_res_dz;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic             r_busy;

  logic [63:0] w_res;
  logic        w_div_by_zero;
  logic        w_is_mul;
  logic        w_is_div;
  logic        w_accept;
  logic        w_start;

  md_arith u_arith (
    .i_a           (md_if.src_a),
    .i_b           (md_if.src_b),
    .i_op          (md_if.op),
    .o_res         (w_res),
    .o_div_by_zero (w_div_by_zero)
  );

  assign w_is_mul = (md_if.op == OP_MULT) || (md_if.op == OP_MULTU);
  assign w_is_div = (md_if.op == OP_DIV)  || (md_if.op == OP_DIVU);
  assign w_accept = reset && md_if.op_valid && !md_if.clear && (r_state == ST_IDLE);
  assign w_start  = w_accept && (w_is_mul || w_is_div);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_res    <= '0;
      r_res_dz <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_res    <= w_res;
            r_res_dz <= w_div_by_zero;
            r_busy   <= 1'b1;
            if (w_is_mul) begin
              r_cnt   <= CNT_W'(MULT_LAT);
              r_state <= ST_MUL_RUN;
            end else begin
              r_cnt   <= CNT_W'(DIV_LAT);
              r_state <= ST_DIV_RUN;
            end
          end else if (w_accept && md_if.op == OP_MTHI) begin
            r_hi <= md_if.src_a;
          end else if (w_accept && md_if.op == OP_MTLO) begin
            r_lo <= md_if.src_a;
          end
        end
        ST_MUL_RUN, ST_DIV_RUN: begin
          // A flush always wins, even on the final counting cycle.
          if (md_if.clear) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else if (r_cnt == CNT_W'(1)) begin
            if (!r_res_dz) begin
              r_hi <= r_res[63:32];
              r_lo <= r_res[31:0];
            end
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign md_if.start  = w_start;
  assign md_if.busy   = r_busy;
  assign md_if.stall  = reset && md_if.id_md && (r_busy || w_start);
  assign md_if.md_out = !reset                  ? 32'd0 :
                        (md_if.op == OP_MFHI)   ? r_hi  :
                        (md_if.op == OP_MFLO)   ? r_lo  : 32'd0;

endmodule

// File: tb/tb_md_sched.sv
// Self-checking bench for md_sched: directed scenarios plus random traffic,
// all compared against a cycle-level behavioural model of HI/LO.
module tb_md_sched;
  import md_pkg::*;

  localparam int ML = 5;
  localparam int DL = 10;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  md_sched_if bus ();

  md_sched #(.MULT_LAT(ML), .DIV_LAT(DL)) dut (
    .clk   (clk),
    .reset (reset),
    .md_if (bus.slave)
  );

  // Reference model: architectural HI/LO, cycles of busy left, pending result.
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  int          m_rem = 0;
  logic [63:0] m_pend = '0;
  bit          m_pend_ok = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit v, input logic [3:0] o, input logic [31:0] a,
                            input logic [31:0] b, input bit clr);
    longint          sa, sb, q, r;
    longint unsigned ua, ub;
    if (!reset) begin
      m_hi = '0; m_lo = '0; m_rem = 0;
    end else if (m_rem > 0) begin
      if (clr) m_rem = 0;
      else if (m_rem == 1) begin
        if (m_pend_ok) {m_hi, m_lo} = m_pend;
        m_rem = 0;
      end else m_rem--;
    end else if (v && !clr) begin
      sa = longint'($signed(a)); sb = longint'($signed(b));
      ua = longint'(a);          ub = longint'(b);
      case (o)
        OP_MULT:  begin m_pend = sa * sb; m_pend_ok = 1; m_rem = ML; end
        OP_MULTU: begin m_pend = ua * ub; m_pend_ok = 1; m_rem = ML; end
        OP_DIV: begin
          m_pend_ok = (b != 0); m_rem = DL;
          if (b != 0) begin q = sa / sb; r = sa % sb; m_pend = {r[31:0], q[31:0]}; end
        end
        OP_DIVU: begin
          m_pend_ok = (b != 0); m_rem = DL;
          if (b != 0) m_pend = {32'(ua % ub), 32'(ua / ub)};
        end
        OP_MTHI: m_hi = a;
        OP_MTLO: m_lo = a;
        default: ;
      endcase
    end
  endtask

  task automatic step(input bit v, input logic [3:0] o, input logic [31:0] a,
                      input logic [31:0] b, input bit clr, input bit id);
    bit arith, exp_start;
    logic [31:0] exp_out;
    @(negedge clk);
    bus.op_valid = v; bus.op = o; bus.src_a = a; bus.src_b = b;
    bus.clear = clr; bus.id_md = id;
    #1;
    arith     = (o == OP_MULT) || (o == OP_MULTU) || (o == OP_DIV) || (o == OP_DIVU);
    exp_start = reset && v && !clr && (m_rem == 0) && arith;
    exp_out   = !reset ? 32'd0 : (o == OP_MFHI) ? m_hi : (o == OP_MFLO) ? m_lo : 32'd0;
    chk("busy",   bus.busy,   m_rem != 0);
    chk("start",  bus.start,  exp_start);
    chk("stall",  bus.stall,  reset && id && (m_rem != 0 || exp_start));
    chk("md_out", bus.md_out, exp_out);
    @(posedge clk);
    model_edge(v, o, a, b, clr);
  endtask

  task automatic idle(input int n, input bit id);
    for (int i = 0; i < n; i++) step(0, OP_NONE, 0, 0, 0, id);
  endtask

  task automatic peek(input string tag, input logic [3:0] o, input logic [31:0] exp);
    step(1, o, 0, 0, 0, 0);
    #1 chk(tag, bus.md_out, exp);
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bus.op_valid = 0; bus.op = OP_NONE; bus.src_a = 0; bus.src_b = 0;
    bus.clear = 0; bus.id_md = 0;

    // Held in reset: requests must be refused and outputs quiet.
    step(1, OP_MULT, 3, 4, 0, 1);
    step(1, OP_MFHI, 0, 0, 0, 1);
    step(0, OP_NONE, 0, 0, 0, 0);
    reset = 1'b1;
    idle(1, 0);

    // Signed multiply with negative operand.
    step(1, OP_MULT, 32'hFFFF_FFFE, 32'd3, 0, 0);
    idle(ML, 0);
    peek("r039_hi", OP_MFHI, 32'hFFFF_FFFF);
    peek("r039_lo", OP_MFLO, 32'hFFFF_FFFA);

    // Signed divide truncating toward zero.
    step(1, OP_DIV, 32'hFFFF_FFF9, 32'd2, 0, 0);
    idle(DL, 0);
    peek("r040_lo", OP_MFLO, 32'hFFFF_FFFD);
    peek("r040_hi", OP_MFHI, 32'hFFFF_FFFF);

    // Divide by zero leaves HI/LO intact.
    step(1, OP_MTHI, 32'h11, 0, 0, 0);
    step(1, OP_MTLO, 32'h22, 0, 0, 0);
    step(1, OP_DIVU, 32'd5, 32'd0, 0, 0);
    idle(DL, 0);
    peek("r041_hi", OP_MFHI, 32'h11);
    peek("r041_lo", OP_MFLO, 32'h22);

    // Unsigned multiply with ID stalled throughout.
    step(1, OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1);
    idle(ML, 1);
    peek("r042_hi", OP_MFHI, 32'hFFFF_FFFE);
    peek("r042_lo", OP_MFLO, 32'h1);

    // Overflowing signed divide.
    step(1, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    idle(DL, 0);
    peek("r023_lo", OP_MFLO, 32'h8000_0000);
    peek("r023_hi", OP_MFHI, 32'h0);

    // Flush mid-divide, then immediate multiply.
    step(1, OP_DIV, 32'd100, 32'd7, 0, 0);
    idle(3, 0);
    step(0, OP_NONE, 0, 0, 1, 0);
    step(1, OP_MULT, 32'd2, 32'd3, 0, 0);
    idle(ML, 0);
    peek("r043_lo", OP_MFLO, 32'd6);

    // Flush on the final counting cycle, and clear with a presented op.
    step(1, OP_DIVU, 32'd100, 32'd7, 0, 0);
    idle(DL - 1, 0);
    step(0, OP_NONE, 0, 0, 1, 0);
    step(1, OP_MTHI, 32'hDEAD, 0, 1, 1);
    peek("r030_lo", OP_MFLO, 32'd6);
    peek("r030_hi", OP_MFHI, 32'd0);

    // Asynchronous reset mid-multiply.
    step(1, OP_MULT, 32'hFFFF_FFFE, 32'd3, 0, 0);
    idle(2, 0);
    bus.op = OP_MFLO;
    #3 reset = 1'b0;
    #1 chk("r044_busy", bus.busy, 1'b0);
    chk("r044_lo_rst", bus.md_out, 32'd0);
    model_edge(0, OP_NONE, 0, 0, 0);
    step(1, OP_MULT, 5, 5, 0, 1);
    step(0, OP_NONE, 0, 0, 0, 0);
    reset = 1'b1;
    peek("r044_hi", OP_MFHI, 32'd0);
    peek("r044_lo", OP_MFLO, 32'd0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 1), 4'($urandom_range(0, 8)), rnd_val(), rnd_val(),
           ($urandom_range(0, 15) == 0), $urandom_range(0, 1));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
